user_pulse_decoder: RTL
=======================

Name: user_pulse_decoder

Overview:
Receive-side counterpart of the user-domain pulse-train generator. It samples an external pulse line and measures each pulse's period and high time. Pulses are grouped into up to two constant-frequency segments (F1, F2), and the train is closed by an idle timeout. Results sit in user-domain registers for software readback; it runs on the user-domain clock.

Parameters:
SYNC_STAGES, 2, flip-flop stages on pulse_i before edge detection (min 2)
CNT_W, 16, width of cycle counters, period/high results, timeout
NUM_W, 8, width of per-segment pulse counts

Ports:
clk_i  in  1  user-domain clock
rst_ni  in  1  reset, asynchronous, active-low
pulse_i  in  1  asynchronous pulse line under measurement
arm_i  in  1  single-cycle: clear results, wait for first rising edge
abort_i  in  1  single-cycle: return to IDLE, results kept
tolerance_i  in  NUM_W  max |period - segment reference period| counted as same segment
timeout_i  in  CNT_W  idle cycles after last rising edge that end the train
seg0_count_o / seg1_count_o  out  NUM_W  pulses attributed to segment 0 / 1
seg0_period_o / seg1_period_o  out  CNT_W  reference period (cycles) of segment
seg0_high_o / seg1_high_o  out  CNT_W  high time (cycles) of segment's first pulse
busy_o  out  1  state is ARMED or MEASURE
done_o  out  1  level, high in DONE
error_o  out  1  third segment seen or count saturated
state_o  out  2  current FSM state

Behaviour:
- Reset: FSM IDLE; all result outputs 0; busy_o, done_o, error_o 0.
- Input path: pulse_i passes SYNC_STAGES flops. A rising edge is detected when the synced value is 1 and the previous synced value is 0. Latency from pin to edge detect is SYNC_STAGES+1 cycles.
- Period counter per_cnt: loads 1 on every rising edge, otherwise increments, saturating at all-ones. Period sampled at an edge = per_cnt before load, i.e. edge-to-edge distance in cycles.
- High counter hi_cnt: loads 1 on a rising edge, increments while synced line is 1, holds while 0, saturates.
- States IDLE(0), ARMED(1), MEASURE(2), DONE(3):
  IDLE: arm_i -> ARMED.
  ARMED: first rising edge -> MEASURE. No timeout here.
  MEASURE: every rising edge closes the previous pulse (period P, high H). When per_cnt == max(timeout_i,2) with no edge, the final pulse is closed with P = 0 -> DONE.
  DONE: holds results; arm_i -> ARMED (results cleared).
- abort_i from any state -> IDLE, results and error unchanged. abort_i beats arm_i in the same cycle. arm_i in ARMED or MEASURE restarts: clear results, go to ARMED.
- Pulse attribution (closing pulse with P, H):
  - No segment open: open seg0 with period = P, high = H, count = 1.
  - P = 0 (timeout close): add to the current segment.
  - |P - ref| <= tolerance_i (unsigned, CNT_W+1-bit difference): current segment count++.
  - Mismatch in seg0: open seg1 with P, H, count 1.
  - Mismatch in seg1: error_o = 1, go to DONE immediately.
- A single pulse followed by timeout gives seg0 count 1, period 0, high H.
- Count reaching all-ones saturates and sets error_o; measurement continues.
- An edge and the timeout in the same cycle: the edge wins.
- Outputs are registered and update the cycle after the closing event. done_o rises the cycle after the timeout hit.

Decomposition:
- Package user_pulse_pkg: state enum (2 bits, encodings above) and the default SYNC_STAGES constant.
- Sub-module user_pulse_edge_sync: synchronizer chain plus rising-edge pulse output.
- Counters are plain saturating registers, not common_cells counter, because of the load-1 semantics.

Test Plan:
- Two-segment train: arm; pulse_i gives 4 pulses of period 10 / high 5, then 3 pulses of period 6 / high 3; tolerance 0, timeout 50 -> seg0 = 4/10/5, seg1 = 3/6/3, error 0. done_o rises 50 cycles after the last edge plus 1 cycle.
- Jitter: 5 pulses with periods 10, 11, 9, 10, tolerance 1 -> seg0 count 5, period 10, seg1 count 0. Same stimulus with tolerance 0 -> error_o = 1 at the third differing period.
- Single pulse: arm, one 7-cycle-high pulse, timeout 20 -> seg0 = 1/0/7, done_o after 20 idle cycles.
- Abort mid-train: abort_i after 2 pulses -> state IDLE, busy 0, done 0, partial results held. A later arm_i clears all results.
- Simultaneous abort_i and arm_i in DONE -> IDLE. Asynchronous reset during MEASURE -> all outputs 0 immediately; no state change until the next arm.
- Saturation: 300 pulses of period 4 -> seg0 count 255, error_o 1, done after timeout.

Source files
------------

// File: rtl/user_pulse_pkg.sv
// -----------------------------------------------------------------------------
// user_pulse_pkg
// Shared definitions for the user-domain pulse-train decoder.
//   upd_state_e          : decoder FSM state (IDLE=0, ARMED=1, MEASURE=2, DONE=3)
//   DEFAULT_SYNC_STAGES  : default synchronizer depth on the pulse input
// -----------------------------------------------------------------------------
package user_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } upd_state_e;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/user_pulse_edge_sync.sv
// -----------------------------------------------------------------------------
// user_pulse_edge_sync
// Synchronizes an asynchronous pulse line into clk_i and flags rising edges.
//   clk_i    : user-domain clock
//   rst_ni   : asynchronous active-low reset
//   pulse_i  : asynchronous input line (SYNC_STAGES >= 2)
//   level_o  : synchronized line, aligned with rise_o
//   rise_o   : one-cycle rising-edge strobe, SYNC_STAGES+1 cycles after the pin
// -----------------------------------------------------------------------------
module user_pulse_edge_sync
    import user_pulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pulse_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // prev_q holds the same sample that produced rise_q, so the level seen by
    // the counters is 1 in the cycle the edge strobe is presented.
    assign level_o = prev_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/user_pulse_decoder.sv
// -----------------------------------------------------------------------------
// user_pulse_decoder
// Measures period and high time of each pulse on an external line and groups
// pulses into up to two constant-frequency segments; an idle timeout closes
// the train.
//   clk_i, rst_ni          : user-domain clock, asynchronous active-low reset
//   pulse_i                : asynchronous pulse line
//   arm_i                  : clear results and wait for the first rising edge
//   abort_i                : return to IDLE keeping results (wins over arm_i)
//   tolerance_i            : max |period - reference| accepted into a segment
//   timeout_i              : idle cycles after the last edge ending the train
//   seg{0,1}_count_o       : pulses attributed to each segment
//   seg{0,1}_period_o      : reference period of each segment (cycles)
//   seg{0,1}_high_o        : high time of each segment's first pulse
//   busy_o, done_o         : ARMED/MEASURE, DONE
//   error_o                : third segment seen or count saturated
//   state_o                : current FSM state
// -----------------------------------------------------------------------------
module user_pulse_decoder
    import user_pulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pulse_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [NUM_W-1:0] tolerance_i,
    input  logic [CNT_W-1:0] timeout_i,
    output logic [NUM_W-1:0] seg0_count_o,
    output logic [NUM_W-1:0] seg1_count_o,
    output logic [CNT_W-1:0] seg0_period_o,
    output logic [CNT_W-1:0] seg1_period_o,
    output logic [CNT_W-1:0] seg0_high_o,
    output logic [CNT_W-1:0] seg1_high_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [1:0]       state_o
);

    logic rise;
    logic level;

    user_pulse_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pulse_i(pulse_i),
        .level_o(level),
        .rise_o (rise)
    );

    // Period / high counters: load 1 on an edge so that the value seen at the
    // next edge is the edge-to-edge distance (period) and the high time.
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else begin
            if (per_cnt != '1) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
            if (level && (hi_cnt != '1)) begin
                hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

    upd_state_e       state_q;
    logic [1:0]       seg_used_q;   // number of segments opened so far

    // Attribution of the pulse being closed this cycle.
    logic [CNT_W-1:0] close_p;
    logic [CNT_W-1:0] ref_p;
    logic [NUM_W-1:0] cur_cnt;
    logic [NUM_W-1:0] cnt_next;
    logic [CNT_W:0]   abs_diff;
    logic             in_tol;
    logic [CNT_W-1:0] tmo_eff;
    logic             timeout_hit;

    always_comb begin
        close_p  = rise ? per_cnt : '0;
        ref_p    = (seg_used_q == 2'd2) ? seg1_period_o : seg0_period_o;
        cur_cnt  = (seg_used_q == 2'd2) ? seg1_count_o : seg0_count_o;
        cnt_next = (cur_cnt == '1) ? cur_cnt : cur_cnt + NUM_W'(1);
        if (close_p >= ref_p) begin
            abs_diff = {1'b0, close_p} - {1'b0, ref_p};
        end else begin
            abs_diff = {1'b0, ref_p} - {1'b0, close_p};
        end
        in_tol      = (abs_diff <= (CNT_W+1)'(tolerance_i));
        tmo_eff     = (timeout_i < CNT_W'(2)) ? CNT_W'(2) : timeout_i;
        timeout_hit = !rise && (per_cnt == tmo_eff);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            seg_used_q    <= '0;
            seg0_count_o  <= '0;
            seg1_count_o  <= '0;
            seg0_period_o <= '0;
            seg1_period_o <= '0;
            seg0_high_o   <= '0;
            seg1_high_o   <= '0;
            error_o       <= 1'b0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
        end else if (arm_i) begin
            state_q       <= ST_ARMED;
            seg_used_q    <= '0;
            seg0_count_o  <= '0;
            seg1_count_o  <= '0;
            seg0_period_o <= '0;
            seg1_period_o <= '0;
            seg0_high_o   <= '0;
            seg1_high_o   <= '0;
            error_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (rise) begin
                        state_q <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise || timeout_hit) begin
                        if (!rise) begin
                            state_q <= ST_DONE;
                        end
                        if (seg_used_q == 2'd0) begin
                            seg0_period_o <= close_p;
                            seg0_high_o   <= hi_cnt;
                            seg0_count_o  <= NUM_W'(1);
                            seg_used_q    <= 2'd1;
                        end else if (!rise || in_tol) begin
                            // Timeout closes always join the open segment.
                            if (seg_used_q == 2'd1) begin
                                seg0_count_o <= cnt_next;
                            end else begin
                                seg1_count_o <= cnt_next;
                            end
                            if (cnt_next == '1) begin
                                error_o <= 1'b1;
                            end
                        end else if (seg_used_q == 2'd1) begin
                            seg1_period_o <= close_p;
                            seg1_high_o   <= hi_cnt;
                            seg1_count_o  <= NUM_W'(1);
                            seg_used_q    <= 2'd2;
                        end else begin
                            error_o <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state_q == ST_ARMED) || (state_q == ST_MEASURE);
    assign done_o  = (state_q == ST_DONE);
    assign state_o = state_q;

endmodule
